// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    s_IDLE,
    s_RX_START_BIT,
    s_RX_DATA_BITS,
    s_RX_STOP_BIT,
    s_CLEANUP
  } state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_bit_index.sv
// Data-bit position tracker for the UART receiver; bit_done flags the sample of the last data bit.
module uart_rx_bit_index
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  state_t      current_state,
  input  logic [15:0] clock_count,
  output logic [2:0]  bit_index,
  output logic        bit_done
);

  localparam logic [15:0] LAST    = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  IDX_MAX = 3'(DATA_BITS - 1);

  logic [2:0] idx_q;
  logic       sample;

  assign sample    = (current_state == s_RX_DATA_BITS) && (clock_count == LAST);
  assign bit_done  = sample && (idx_q == IDX_MAX);
  assign bit_index = idx_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      idx_q <= 3'd0;
    end else if (current_state == s_IDLE) begin
      idx_q <= 3'd0;
    end else if (sample) begin
      idx_q <= bit_done ? 3'd0 : idx_q + 3'd1;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: two-flop synchroniser, start-edge detect, mid-bit sampling,
// one-cycle good-byte and framing-error strobes.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Busy
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]           warm_q;
  logic                 fall_edge;
  state_t               state_q;
  logic [15:0]          clk_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_index;
  logic                 bit_done;
  logic                 dv_q, err_q, busy_q;
  logic [7:0]           byte_q;

  // rx_prev_q is held low until the real line has reached rx_sync_q, so the
  // reset value of the synchroniser can never fake the high half of a start edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b0;
      warm_q    <= 2'b00;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
      warm_q    <= {warm_q[0], 1'b1};
      rx_prev_q <= warm_q[1] & rx_sync_q;
    end
  end

  assign fall_edge = rx_prev_q & ~rx_sync_q;

  uart_rx_bit_index #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_index (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .current_state(state_q),
    .clock_count  (clk_cnt_q),
    .bit_index    (bit_index),
    .bit_done     (bit_done)
  );

  always_ff @(posedge i_Clock) begin
    if ((state_q == s_RX_DATA_BITS) && (clk_cnt_q == LAST)) begin
      shift_q[bit_index] <= rx_sync_q;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= s_IDLE;
      clk_cnt_q <= 16'd0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      byte_q    <= 8'h00;
    end else begin
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        s_IDLE: begin
          clk_cnt_q <= 16'd0;
          if (fall_edge) begin
            state_q <= s_RX_START_BIT;
            busy_q  <= 1'b1;
          end
        end
        s_RX_START_BIT: begin
          if (clk_cnt_q == HALF) begin
            clk_cnt_q <= 16'd0;
            if (!rx_sync_q) begin
              state_q <= s_RX_DATA_BITS;
            end else begin
              state_q <= s_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        s_RX_DATA_BITS: begin
          if (clk_cnt_q == LAST) begin
            clk_cnt_q <= 16'd0;
            if (bit_done) state_q <= s_RX_STOP_BIT;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        s_RX_STOP_BIT: begin
          if (clk_cnt_q == LAST) begin
            clk_cnt_q <= 16'd0;
            state_q   <= s_CLEANUP;
            if (rx_sync_q) begin
              byte_q <= shift_q;
              dv_q   <= 1'b1;
            end else begin
              err_q  <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        s_CLEANUP: begin
          // Keep watching for a start edge so back-to-back frames are not lost.
          clk_cnt_q <= 16'd0;
          if (fall_edge) begin
            state_q <= s_RX_START_BIT;
          end else begin
            state_q <= s_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= s_IDLE;
          clk_cnt_q <= 16'd0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Frame_Err = err_q;
  assign o_Rx_Busy      = busy_q;
  assign o_Rx_Byte      = byte_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table-driven frames plus hand-written corner sequences.
module tb_uart_rx_frame;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv, err, busy;
  logic [7:0] rbyte;

  always #5 clk = ~clk;

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Rx_Serial   (rx),
    .o_Rx_DV       (dv),
    .o_Rx_Byte     (rbyte),
    .o_Rx_Frame_Err(err),
    .o_Rx_Busy     (busy)
  );

  typedef struct packed {
    logic       dv;
    logic       err;
    logic [7:0] dat;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_dv;
    logic [7:0] exp_byte;
  } vec_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  total = 0;
  int  bad   = 0;

  // Record every strobe the DUT produces; comparisons happen in the main thread.
  always @(negedge clk) begin
    if (dv || err) obs_q.push_back({dv, err, rbyte});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic bit_period(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    bit_period(stop);
  endtask

  task automatic drain(input string nm);
    int  t;
    ev_t e;
    ev_t o;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 40 * CPB) begin
      @(negedge clk);
      t++;
    end
    repeat (2 * CPB) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_missing: got no strobe, want dv=%0b err=%0b byte=%0h", nm, e.dv, e.err, e.dat);
      end else begin
        o = obs_q.pop_front();
        chk({nm, "_dv"}, 32'(o.dv), 32'(e.dv));
        chk({nm, "_err"}, 32'(o.err), 32'(e.err));
        chk({nm, "_byte"}, 32'(o.dat), 32'(e.dat));
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s_extra: got dv=%0b err=%0b byte=%0h, want no strobe", nm, o.dv, o.err, o.dat);
    end
  endtask

  vec_t vecs[6];
  logic saw;

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_dv: 1'b1, exp_byte: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_dv: 1'b0, exp_byte: 8'hA5};
    vecs[2] = '{data: 8'h5A, stop: 1'b1, exp_dv: 1'b1, exp_byte: 8'h5A};
    vecs[3] = '{data: 8'hC3, stop: 1'b0, exp_dv: 1'b0, exp_byte: 8'h5A};
    vecs[4] = '{data: 8'h01, stop: 1'b1, exp_dv: 1'b1, exp_byte: 8'h01};
    vecs[5] = '{data: 8'h80, stop: 1'b1, exp_dv: 1'b1, exp_byte: 8'h80};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dv", 32'(dv), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_byte", 32'(rbyte), 32'h00);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].exp_dv, ~vecs[i].exp_dv, vecs[i].exp_byte});
      send(vecs[i].data, vecs[i].stop);
      bit_period(1'b1);
      bit_period(1'b1);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_hold", i), 32'(rbyte), 32'(vecs[i].exp_byte));
      chk($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end

    // Two-cycle low glitch: start detected, rejected at mid start bit.
    saw = 1'b0;
    rx  = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    chk("glitch_busy_seen", 32'(saw), 32'd1);
    chk("glitch_busy_clear", 32'(busy), 32'd0);
    drain("glitch");
    chk("glitch_hold", 32'(rbyte), 32'h80);

    // Back-to-back frames with no idle gap.
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    exp_q.push_back({1'b1, 1'b0, 8'hFF});
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    bit_period(1'b1);
    drain("b2b");

    // Reset during data bit 4 of 8'h55; the transmitter aborts too.
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'(8'h55 >> i));
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dv", 32'(dv), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_byte", 32'(rbyte), 32'h00);
    rst = 1'b0;
    bit_period(1'b1);
    bit_period(1'b1);
    drain("midrst");
    exp_q.push_back({1'b1, 1'b0, 8'h81});
    send(8'h81, 1'b1);
    bit_period(1'b1);
    drain("after_rst");
    chk("after_rst_hold", 32'(rbyte), 32'h81);

    // Break: line held low through and beyond a whole frame.
    exp_q.push_back({1'b0, 1'b1, 8'h81});
    rx = 1'b0;
    repeat (14 * CPB) @(negedge clk);
    drain("break");
    saw = 1'b0;
    repeat (4 * CPB) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    chk("break_no_restart", 32'(saw), 32'd0);
    drain("break_quiet");
    bit_period(1'b1);
    exp_q.push_back({1'b1, 1'b0, 8'h7E});
    send(8'h7E, 1'b1);
    bit_period(1'b1);
    drain("break_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
